// File: rtl/karatsuba_pipe_multiplier_if.sv
`timescale 1ns/1ps
// karatsuba_pipe_multiplier_if
// Streaming bundle for the Karatsuba multiplier. It carries the operand-pair
// handshake, the result handshake and the last-beat sideband.
// The acc_sum result field exists only when CONV_MULT_ACCUM_EN is defined.
interface karatsuba_pipe_multiplier_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH+8
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic [WIDTH-1:0]     factor1;
    logic [WIDTH-1:0]     factor2;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic [2*WIDTH-1:0]   product;
`ifdef CONV_MULT_ACCUM_EN
    logic [ACC_WIDTH-1:0] acc_sum;
`endif

    // The source of operands and the sink of results.
    modport master (
        output in_valid, in_last, factor1, factor2, out_ready,
        input  in_ready, out_valid, out_last, product
`ifdef CONV_MULT_ACCUM_EN
        , input acc_sum
`endif
    );

    // The multiplier itself.
    modport slave (
        input  in_valid, in_last, factor1, factor2, out_ready,
        output in_ready, out_valid, out_last, product
`ifdef CONV_MULT_ACCUM_EN
        , output acc_sum
`endif
    );

    // An accumulator narrower than one product would silently drop product
    // bits; this named block marks such a configuration in elaboration.
    if (ACC_WIDTH < 2*WIDTH) begin : g_acc_narrower_than_product
    end
endinterface

// File: rtl/karatsuba_pipe_multiplier.sv
`timescale 1ns/1ps
// karatsuba_pipe_multiplier
// Three-stage pipelined Karatsuba unsigned multiplier (split, partial
// products, combine) with a valid/ready stream and a last-beat sideband.
// A single global stall (result valid but not taken) freezes every stage.
// Defining CONV_MULT_ACCUM_EN adds a fourth stage holding a dot-product
// accumulator that clears after each last beat; latency then becomes 4.
module karatsuba_pipe_multiplier #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH+8
) (
    input  logic                       clk,
    input  logic                       rst,
    karatsuba_pipe_multiplier_if.slave bus
);
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    // Half-width sum; the extra bit keeps the carry.
    function automatic logic [H:0] half_sum(input logic [H-1:0] p, input logic [H-1:0] q);
        return {1'b0, p} + {1'b0, q};
    endfunction

    // Half-width by half-width product at full 2H width.
    function automatic logic [2*H-1:0] half_mul(input logic [H-1:0] p, input logic [H-1:0] q);
        return {{H{1'b0}}, p} * {{H{1'b0}}, q};
    endfunction

    // (H+1)-bit by (H+1)-bit product at full 2H+2 width.
    function automatic logic [2*H+1:0] sum_mul(input logic [H:0] p, input logic [H:0] q);
        return {{(H+1){1'b0}}, p} * {{(H+1){1'b0}}, q};
    endfunction

    // Karatsuba recombination. mid = ad + bc, so it is never negative and
    // fits in 2H+1 bits; the final sum is exact in 2*WIDTH bits.
    function automatic logic [PW-1:0] combine(input logic [2*H-1:0] ac,
                                              input logic [2*H-1:0] bd,
                                              input logic [2*H+1:0] m);
        logic [2*H+1:0] mid;
        mid = m - {2'b00, ac} - {2'b00, bd};
        return {ac, {WIDTH{1'b0}}}
             + ({{(PW-2*H-2){1'b0}}, mid} << H)
             + {{WIDTH{1'b0}}, bd};
    endfunction

    logic           w_stall;
    logic           w_adv;
    logic           w_out_valid;
    logic [H-1:0]   w_a, w_b, w_c, w_d;

    logic           r_vld_p1, r_last_p1;
    logic [H-1:0]   r_a_p1, r_b_p1, r_c_p1, r_d_p1;
    logic [H:0]     r_sab_p1, r_scd_p1;

    logic           r_vld_p2, r_last_p2;
    logic [2*H-1:0] r_ac_p2, r_bd_p2;
    logic [2*H+1:0] r_m_p2;

    logic           r_vld_p3, r_last_p3;
    logic [PW-1:0]  r_prod_p3;

    assign w_stall     = w_out_valid & ~bus.out_ready;
    assign w_adv       = ~w_stall;
    assign bus.in_ready = w_adv;

    assign w_a = bus.factor1[WIDTH-1:H];
    assign w_b = bus.factor1[H-1:0];
    assign w_c = bus.factor2[WIDTH-1:H];
    assign w_d = bus.factor2[H-1:0];

    // ---- S1: split ----
    // S1 control: accept a pair (or a bubble) whenever the pipe advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1  <= bus.in_valid;
            r_last_p1 <= bus.in_last;
        end
    end

    // S1 data: operand halves and the two carry-preserving half sums.
    always_ff @(posedge clk) begin
        if (w_adv && bus.in_valid) begin
            r_a_p1   <= w_a;
            r_b_p1   <= w_b;
            r_c_p1   <= w_c;
            r_d_p1   <= w_d;
            r_sab_p1 <= half_sum(w_a, w_b);
            r_scd_p1 <= half_sum(w_c, w_d);
        end
    end

    // ---- S2: partial products ----
    // S2 control: move valid/last forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_last_p2 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p2  <= r_vld_p1;
            r_last_p2 <= r_last_p1;
        end
    end

    // S2 data: the three Karatsuba multiplications.
    always_ff @(posedge clk) begin
        if (w_adv && r_vld_p1) begin
            r_ac_p2 <= half_mul(r_a_p1, r_c_p1);
            r_bd_p2 <= half_mul(r_b_p1, r_d_p1);
            r_m_p2  <= sum_mul(r_sab_p1, r_scd_p1);
        end
    end

    // ---- S3: combine ----
    // S3: a bubble clears the valid bit but leaves product/last untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p3  <= 1'b0;
            r_last_p3 <= 1'b0;
            r_prod_p3 <= '0;
        end else if (w_adv) begin
            r_vld_p3 <= r_vld_p2;
            if (r_vld_p2) begin
                r_last_p3 <= r_last_p2;
                r_prod_p3 <= combine(r_ac_p2, r_bd_p2, r_m_p2);
            end
        end
    end

`ifdef CONV_MULT_ACCUM_EN
    // Running sum that wraps modulo 2^ACC_WIDTH.
    function automatic logic [ACC_WIDTH-1:0] acc_wrap_add(input logic [ACC_WIDTH-1:0] acc,
                                                          input logic [PW-1:0]        prod);
        return acc + ACC_WIDTH'(prod);
    endfunction

    logic                 w_acc_next;
    logic [ACC_WIDTH-1:0] w_acc_sum_next;
    logic                 r_vld_p4, r_last_p4;
    logic [PW-1:0]        r_prod_p4;
    logic [ACC_WIDTH-1:0] r_sum_p4;
    logic [ACC_WIDTH-1:0] r_acc;

    assign w_acc_next     = w_adv & r_vld_p3;
    assign w_acc_sum_next = acc_wrap_add(r_acc, r_prod_p3);

    // ---- S4: accumulate ----
    // S4: publish the running sum and restart the window after a last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p4  <= 1'b0;
            r_last_p4 <= 1'b0;
            r_prod_p4 <= '0;
            r_sum_p4  <= '0;
            r_acc     <= '0;
        end else begin
            if (w_adv) begin
                r_vld_p4 <= r_vld_p3;
            end
            if (w_acc_next) begin
                r_last_p4 <= r_last_p3;
                r_prod_p4 <= r_prod_p3;
                r_sum_p4  <= w_acc_sum_next;
                r_acc     <= r_last_p3 ? '0 : w_acc_sum_next;
            end
        end
    end

    assign w_out_valid   = r_vld_p4;
    assign bus.out_valid = r_vld_p4;
    assign bus.out_last  = r_last_p4;
    assign bus.product   = r_prod_p4;
    assign bus.acc_sum   = r_sum_p4;
`else
    assign w_out_valid   = r_vld_p3;
    assign bus.out_valid = r_vld_p3;
    assign bus.out_last  = r_last_p3;
    assign bus.product   = r_prod_p3;
`endif

    // Marks an accumulator configuration narrower than one product.
    if (ACC_WIDTH < 2*WIDTH) begin : g_acc_narrower_than_product
    end
endmodule

// File: tb/tb_karatsuba_pipe_multiplier.sv
`timescale 1ns/1ps
// Testbench for karatsuba_pipe_multiplier: a WIDTH=8 instance exercised with
// a vector table, directed corner sequences and randomized streams against a
// queue-based reference, plus a WIDTH=16 instance with directed vectors.
module tb_karatsuba_pipe_multiplier;
    localparam int W8   = 8;
    localparam int W16  = 16;
    localparam int AW8  = 2*W8+8;
    localparam int AW16 = 2*W16+8;
`ifdef CONV_MULT_ACCUM_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    typedef struct { logic [7:0] x; logic [7:0] y; logic last; logic [15:0] prod; } vec_t;
    typedef struct { logic [15:0] prod; logic last; logic [AW8-1:0] acc; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    karatsuba_pipe_multiplier_if #(.WIDTH(W8),  .ACC_WIDTH(AW8))  bus8 ();
    karatsuba_pipe_multiplier_if #(.WIDTH(W16), .ACC_WIDTH(AW16)) bus16 ();

    karatsuba_pipe_multiplier #(.WIDTH(W8),  .ACC_WIDTH(AW8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    karatsuba_pipe_multiplier #(.WIDTH(W16), .ACC_WIDTH(AW16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    int             n_cmp = 0;
    int             n_bad = 0;
    vec_t           tbl[12];
    vec_t           vq[$];
    exp_t           sbq[$];
    logic [AW8-1:0] acc_log[$];
    logic [AW8-1:0] acc_model = '0;
    logic [15:0]    cur_exp = '0;
    bit             did_in, did_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // One clock: record handshakes just before the edge, then land on the next negedge.
    task automatic step();
        exp_t e;
        #1;
        did_in  = bus8.in_valid && bus8.in_ready && !rst;
        did_out = bus8.out_valid && bus8.out_ready && !rst;
        if (did_out) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got product 0x%0h, required no result", bus8.product);
            end else begin
                e = sbq.pop_front();
                check("product", 64'(bus8.product), 64'(e.prod));
                check("out_last", 64'(bus8.out_last), 64'(e.last));
`ifdef CONV_MULT_ACCUM_EN
                check("acc_sum", 64'(bus8.acc_sum), 64'(e.acc));
                acc_log.push_back(bus8.acc_sum);
`endif
            end
        end
        if (did_in) begin
            e.prod    = cur_exp;
            e.last    = bus8.in_last;
            acc_model = acc_model + AW8'(cur_exp);
            e.acc     = acc_model;
            if (bus8.in_last) acc_model = '0;
            sbq.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            sbq.delete();
            acc_model = '0;
        end
        @(negedge clk);
    endtask

    // Feed every entry of vq; optionally random handshakes, one stall burst, strict b2b checks.
    task automatic run_stream(input bit rnd, input int stall_at, input int stall_len, input bit strict);
        int          n, sent, got, stall_cnt, budget, limit;
        bit          stalled;
        logic [15:0] held;
        n = vq.size(); sent = 0; got = 0; stall_cnt = 0; budget = 0; stalled = 0; held = '0;
        limit = 20*n + 50;
        bus8.in_valid = 1'b0;
        while ((got < n) && (budget < limit)) begin
            if (!bus8.in_valid && sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
                bus8.in_valid = 1'b1;
                bus8.factor1  = vq[sent].x;
                bus8.factor2  = vq[sent].y;
                bus8.in_last  = vq[sent].last;
                cur_exp       = vq[sent].prod;
            end
            if (stall_cnt > 0) begin
                bus8.out_ready = 1'b0;
                #1;
                check("stall_in_ready", 64'(bus8.in_ready), 64'd0);
                check("stall_out_valid", 64'(bus8.out_valid), 64'd1);
                check("stall_product_hold", 64'(bus8.product), 64'(held));
                stall_cnt--;
            end else begin
                bus8.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                if (strict && sent < n) check("stream_in_ready", 64'(bus8.in_ready), 64'd1);
            end
            step();
            if (did_in) begin
                sent++;
                bus8.in_valid = 1'b0;
            end
            if (did_out) got++;
            if (strict && got > 0 && got < n) check("no_bubble", 64'(bus8.out_valid), 64'd1);
            if (stall_len > 0 && !stalled && got == stall_at && bus8.out_valid && sbq.size() > 0) begin
                stalled   = 1'b1;
                stall_cnt = stall_len;
                held      = sbq[0].prod;
            end
            budget++;
        end
        if (budget >= limit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_timeout: got %0d of %0d results after %0d cycles", got, n, budget);
        end
        check("stream_sent", 64'(sent), 64'(n));
        check("stream_got", 64'(got), 64'(n));
        check("stream_drained", 64'(sbq.size()), 64'd0);
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        tbl[0]  = '{8'd3,   8'd5,   1'b0, 16'd15};
        tbl[1]  = '{8'd0,   8'd200, 1'b0, 16'd0};
        tbl[2]  = '{8'd128, 8'd2,   1'b0, 16'd256};
        tbl[3]  = '{8'd15,  8'd17,  1'b1, 16'd255};
        tbl[4]  = '{8'd255, 8'd255, 1'b0, 16'hFE01};
        tbl[5]  = '{8'd0,   8'd0,   1'b0, 16'd0};
        tbl[6]  = '{8'd1,   8'd255, 1'b0, 16'd255};
        tbl[7]  = '{8'd240, 8'd15,  1'b0, 16'd3600};
        tbl[8]  = '{8'd170, 8'd85,  1'b1, 16'd14450};
        tbl[9]  = '{8'd128, 8'd128, 1'b0, 16'd16384};
        tbl[10] = '{8'd255, 8'd1,   1'b0, 16'd255};
        tbl[11] = '{8'd254, 8'd253, 1'b1, 16'd64262};

        bus8.in_valid = 1'b0;  bus8.in_last = 1'b0;  bus8.factor1 = '0;  bus8.factor2 = '0;  bus8.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.in_last = 1'b0; bus16.factor1 = '0; bus16.factor2 = '0; bus16.out_ready = 1'b1;
        @(negedge clk);

        // Reset state
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset_out_valid", 64'(bus8.out_valid), 64'd0);
        check("reset_out_last", 64'(bus8.out_last), 64'd0);
        check("reset_product", 64'(bus8.product), 64'd0);
        check("reset_in_ready", 64'(bus8.in_ready), 64'd1);
`ifdef CONV_MULT_ACCUM_EN
        check("reset_acc_sum", 64'(bus8.acc_sum), 64'd0);
`endif
        step();
        check("in_ready_after_reset", 64'(bus8.in_ready), 64'd1);

        // Single 0xFF*0xFF: latency, one-cycle pulse, product held on bubble
        bus8.factor1 = 8'hFF; bus8.factor2 = 8'hFF; bus8.in_last = 1'b0;
        cur_exp = 16'hFE01; bus8.in_valid = 1'b1;
        step();
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 12) begin
            step();
            lat++;
        end
        check("latency", 64'(lat), 64'(LAT));
        check("ff_product", 64'(bus8.product), 64'hFE01);
        step();
        check("pulse_out_valid", 64'(bus8.out_valid), 64'd0);
        check("bubble_hold_product", 64'(bus8.product), 64'hFE01);

        // Back-to-back four pairs, then the same with a 5-cycle stall at result 2
        vq.delete();
        for (int i = 0; i < 4; i++) vq.push_back(tbl[i]);
        run_stream(1'b0, 0, 0, 1'b1);
        run_stream(1'b0, 1, 5, 1'b0);

        // Whole table with random handshakes
        vq.delete();
        for (int i = 0; i < 12; i++) vq.push_back(tbl[i]);
        run_stream(1'b1, 0, 0, 1'b0);

        // Reset while three pairs are in flight
        bus8.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus8.in_valid = 1'b1;
            bus8.factor1  = 8'd7 + 8'(i);
            bus8.factor2  = 8'd9;
            bus8.in_last  = 1'b0;
            cur_exp       = {8'd0, bus8.factor1} * 16'd9;
            step();
        end
        bus8.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midreset_out_valid", 64'(bus8.out_valid), 64'd0);
        check("midreset_product", 64'(bus8.product), 64'd0);
        check("midreset_out_last", 64'(bus8.out_last), 64'd0);
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("no_stale_result", 64'(bus8.out_valid), 64'd0);
        end

        // Randomized stream against the reference queue
        vq.delete();
        for (int i = 0; i < 150; i++) begin
            vec_t v;
            v.x    = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            v.y    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            v.last = ($urandom_range(0, 4) == 0);
            v.prod = {8'd0, v.x} * {8'd0, v.y};
            vq.push_back(v);
        end
        run_stream(1'b1, 0, 0, 1'b0);

`ifdef CONV_MULT_ACCUM_EN
        // Two accumulation windows
        rst = 1'b1;
        step();
        rst = 1'b0;
        vq.delete();
        vq.push_back('{8'd3, 8'd4, 1'b0, 16'd12});
        vq.push_back('{8'd5, 8'd6, 1'b0, 16'd30});
        vq.push_back('{8'd7, 8'd8, 1'b1, 16'd56});
        vq.push_back('{8'd2, 8'd2, 1'b1, 16'd4});
        acc_log.delete();
        run_stream(1'b0, 0, 0, 1'b1);
        check("acc_beats", 64'(acc_log.size()), 64'd4);
        if (acc_log.size() == 4) begin
            check("acc_beat0", 64'(acc_log[0]), 64'd12);
            check("acc_beat1", 64'(acc_log[1]), 64'd42);
            check("acc_beat2", 64'(acc_log[2]), 64'd98);
            check("acc_beat3", 64'(acc_log[3]), 64'd4);
        end
`endif

        // WIDTH=16 instance
        bus16.out_ready = 1'b1;
        bus16.in_valid = 1'b1; bus16.factor1 = 16'hFFFF; bus16.factor2 = 16'hFFFF; bus16.in_last = 1'b0;
        step();
        check("w16_in_ready", 64'(bus16.in_ready), 64'd1);
        bus16.factor1 = 16'h1234; bus16.factor2 = 16'h5678; bus16.in_last = 1'b1;
        step();
        bus16.factor1 = 16'h0000; bus16.factor2 = 16'hFFFF; bus16.in_last = 1'b0;
        step();
        bus16.in_valid = 1'b0;
        for (int k = 3; k < LAT; k++) step();
        check("w16_valid0", 64'(bus16.out_valid), 64'd1);
        check("w16_ffff", 64'(bus16.product), 64'hFFFE0001);
        check("w16_last0", 64'(bus16.out_last), 64'd0);
`ifdef CONV_MULT_ACCUM_EN
        check("w16_acc0", 64'(bus16.acc_sum), 64'hFFFE0001);
`endif
        step();
        check("w16_valid1", 64'(bus16.out_valid), 64'd1);
        check("w16_1234x5678", 64'(bus16.product), 64'h06260060);
        check("w16_last1", 64'(bus16.out_last), 64'd1);
`ifdef CONV_MULT_ACCUM_EN
        check("w16_acc1", 64'(bus16.acc_sum), 64'h106240061);
`endif
        step();
        check("w16_valid2", 64'(bus16.out_valid), 64'd1);
        check("w16_zero", 64'(bus16.product), 64'd0);
        check("w16_last2", 64'(bus16.out_last), 64'd0);
`ifdef CONV_MULT_ACCUM_EN
        check("w16_acc2", 64'(bus16.acc_sum), 64'd0);
`endif
        step();
        check("w16_idle", 64'(bus16.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/karatsuba_pipe_multiplier.md
Name: karatsuba_pipe_multiplier

Overview:
- Parametrised, 3-stage pipelined Karatsuba unsigned multiplier for the convolution datapath.
- Successor to the fixed 8x8 single-register convolution multiplier.
- Adds a generic operand width, a valid/ready streaming handshake with backpressure, and a last-beat sideband.
- Optional dot-product accumulator so one instance can produce a full convolution tap sum.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4; H = WIDTH/2 is the split point.
- ACC_WIDTH, 2*WIDTH+8, accumulator width; used only when CONV_MULT_ACCUM_EN is defined.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- in_last  in  1  marks final pair of a convolution window.
- factor1  in  WIDTH  unsigned operand x.
- factor2  in  WIDTH  unsigned operand y.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_last  out  1  in_last of the pair that produced this result.
- product  out  2*WIDTH  x*y, unsigned.
- acc_sum  out  ACC_WIDTH  running dot-product sum (present only with CONV_MULT_ACCUM_EN).

Behaviour:
- Reset (rst=1 at posedge): all stage valid bits, out_valid, out_last, product and acc_sum go to 0. In-flight data is discarded. in_ready is 1 in the cycle after reset deasserts.
- Global stall: stall = out_valid & ~out_ready. in_ready = ~stall (combinational). When stall=1, every pipeline register holds its value. Otherwise all stages advance together.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - A bubble (in_valid=0) advances as valid=0.
- S1 (split):
  - a = x[WIDTH-1:H], b = x[H-1:0], c = y[WIDTH-1:H], d = y[H-1:0].
  - Register a, b, c, d, sab = a+b and scd = c+d, each sum H+1 bits with no truncation.
  - Register the valid and last bits.
- S2 (products): register ac (2H bits), bd (2H bits) and m = sab*scd (2H+2 bits).
- S3 (combine):
  - mid = m - ac - bd, computed at 2H+2 bits; never negative.
  - product = (ac << WIDTH) + (mid << H) + bd, truncated to 2*WIDTH bits; this is exact.
  - Sets out_valid and out_last.
- Latency: 3 cycles from input transfer to out_valid with no stall. Throughput is 1 result per cycle.
- Output hold: product and out_last stay stable while out_valid & ~out_ready. When a stage advances with a bubble, out_valid drops and product keeps its last value.
- Boundaries:
  - All-ones operands must not overflow intermediate widths.
  - Zero operands yield 0.
  - in_valid asserted during stall is ignored, and the source must hold it.
  - in_valid and out_ready both toggling in one cycle follow the rules above, with no extra bubble.

Optional Feature:
- Macro: CONV_MULT_ACCUM_EN.
- Defined:
  - A 4th register stage adds the accumulator; latency becomes 4.
  - On each S3 result advancing, acc_sum = acc_reg + product, zero-extended to ACC_WIDTH and wrapping modulo 2^ACC_WIDTH.
  - After a beat with last=1 advances, acc_reg clears to 0, so the next window starts fresh.
  - out_valid pulses on every beat; acc_sum on the out_last beat is the window total.
  - Stalls hold the accumulator.
- Undefined: no acc_sum port, no 4th stage, latency 3.

Test Plan:
- Reset, then one pair 0xFF*0xFF (WIDTH=8) with out_ready=1 -> product=0xFE01 exactly 3 cycles after transfer, out_valid high for 1 cycle.
- Stream 4 back-to-back pairs (3*5, 0*200, 128*2, 15*17) -> products 15, 0, 256, 255 on 4 consecutive cycles, in_ready constantly 1.
- Same stream with out_ready=0 for 5 cycles at the 2nd result -> in_ready=0 during stall, product holds 0, no loss or duplication, order preserved.
- rst pulsed 1 cycle while 3 pairs are in flight -> out_valid=0 and product=0 next cycle, no stale results emerge.
- WIDTH=16: 0xFFFF*0xFFFF -> 0xFFFE0001; 0x1234*0x5678 -> 0x06260060.
- CONV_MULT_ACCUM_EN, WIDTH=8: pairs (3,4), (5,6), (7,8, last) then (2,2, last) -> acc_sum 12, 42, 98 with out_last=1 on the 98 beat, then 4 with out_last=1 (accumulator cleared between windows).
